// File: rtl/countdown_pkg.sv
// Shared state, digit types and BCD field helpers for the countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_e;
    typedef logic [3:0] bcd_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    function automatic logic [7:0] to_bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input int maxv);
        logic [7:0] r;
        if (v == to_bcd8(maxv))
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Wraps 00 -> maxv; the caller decides whether to borrow upward.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input int maxv);
        logic [7:0] r;
        if (v == 8'h00)
            r = to_bcd8(maxv);
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_btn_sync_edge.sv
// Button synchroniser plus rising-edge detector producing a registered
// one-cycle pulse, SYNC_STAGES+1 cycles after the raw edge.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q[0] <= btn_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with BCD digit outputs and alarm hold.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the last start time after the alarm.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int CLK_DIV     = 50_000_000,
    parameter int ALARM_SECS  = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic set_sw,
    input  logic btn_s,
    input  logic btn_m,
    input  logic btn_h,
    input  logic btn_go,
    output bcd_t digit_sec0,
    output bcd_t digit_sec1,
    output bcd_t digit_min0,
    output bcd_t digit_min1,
    output bcd_t digit_hour0,
    output bcd_t digit_hour1,
    output logic running,
    output logic alarm
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int AW = $clog2(ALARM_SECS + 1);

    logic s_p, m_p, h_p, go_p;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s (
        .clk_i(clk), .rst_ni(reset), .btn_i(btn_s), .pulse_o(s_p));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_m (
        .clk_i(clk), .rst_ni(reset), .btn_i(btn_m), .pulse_o(m_p));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_h (
        .clk_i(clk), .rst_ni(reset), .btn_i(btn_h), .pulse_o(h_p));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_go (
        .clk_i(clk), .rst_ni(reset), .btn_i(btn_go), .pulse_o(go_p));

    state_e        state_q, state_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          running_q, alarm_q;
    logic          counting, tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [23:0]   preset_q, preset_d;
`endif

    assign counting = (state_q == RUN) || (state_q == ALARM);
    assign tick     = counting && (presc_q == PW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        acnt_d  = acnt_q;
        presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        // Prescaler idles at zero, so every entry to RUN/ALARM starts fresh.
        if (counting)
            presc_d = tick ? '0 : presc_q + PW'(1);
        unique case (state_q)
            IDLE: begin
                if (set_sw) begin
                    if (s_p) sec_d  = bcd_inc(sec_q, SEC_MAX);
                    if (m_p) min_d  = bcd_inc(min_q, MIN_MAX);
                    if (h_p) hour_d = bcd_inc(hour_q, HOUR_MAX);
                end else if (go_p && {hour_q, min_q, sec_q} != 24'h0) begin
                    state_d = RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    preset_d = {hour_q, min_q, sec_q};
`endif
                end
            end
            RUN: begin
                if (tick) begin
                    sec_d = bcd_dec(sec_q, SEC_MAX);
                    if (sec_q == 8'h00) begin
                        min_d = bcd_dec(min_q, MIN_MAX);
                        if (min_q == 8'h00)
                            hour_d = bcd_dec(hour_q, HOUR_MAX);
                    end
                end
                if ({hour_d, min_d, sec_d} == 24'h0) begin
                    state_d = ALARM;
                    acnt_d  = '0;
                end else if (set_sw) begin
                    state_d = IDLE;
                end else if (go_p) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (set_sw)
                    state_d = IDLE;
                else if (go_p)
                    state_d = RUN;
            end
            ALARM: begin
                if (s_p || m_p || h_p || go_p)
                    state_d = IDLE;
                else if (tick) begin
                    if (acnt_q == AW'(ALARM_SECS - 1))
                        state_d = IDLE;
                    else
                        acnt_d = acnt_q + AW'(1);
                end
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (state_d == IDLE)
                    {hour_d, min_d, sec_d} = preset_q;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hour_q    <= 8'h00;
            presc_q   <= '0;
            acnt_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            preset_q  <= 24'h0;
`endif
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            presc_q   <= presc_d;
            acnt_q    <= acnt_d;
            running_q <= (state_d == RUN);
            alarm_q   <= (state_d == ALARM);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            preset_q  <= preset_d;
`endif
        end
    end

    assign digit_sec0  = sec_q[3:0];
    assign digit_sec1  = sec_q[7:4];
    assign digit_min0  = min_q[3:0];
    assign digit_min1  = min_q[7:4];
    assign digit_hour0 = hour_q[3:0];
    assign digit_hour1 = hour_q[7:4];
    assign running     = running_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (CLK_DIV=4, ALARM_SECS=3).
module tb_countdown_timer;

    logic clk = 1'b0;
    logic reset, set_sw, btn_s, btn_m, btn_h, btn_go;
    logic [3:0] s0, s1, m0, m1, h0, h1;
    logic running, alarm;

    always #5 clk = ~clk;

    countdown_timer #(
        .CLK_DIV(4), .ALARM_SECS(3), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .set_sw(set_sw),
        .btn_s(btn_s), .btn_m(btn_m), .btn_h(btn_h), .btn_go(btn_go),
        .digit_sec0(s0), .digit_sec1(s1),
        .digit_min0(m0), .digit_min1(m1),
        .digit_hour0(h0), .digit_hour1(h1),
        .running(running), .alarm(alarm)
    );

    wire [23:0] dig = {h1, h0, m1, m0, s1, s0};

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         ns;
        int         nm;
        int         nh;
        logic [23:0] exp;
    } edit_vec_t;

    edit_vec_t ev[4];

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam logic [23:0] RELOAD_60 = 24'h000100;
    localparam logic [23:0] RELOAD_5  = 24'h000005;
`else
    localparam logic [23:0] RELOAD_60 = 24'h000000;
    localparam logic [23:0] RELOAD_5  = 24'h000000;
`endif

    task automatic chk_d(input string name, input logic [23:0] act,
                         input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act,
                         input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        set_sw = 1'b0;
        {btn_go, btn_h, btn_m, btn_s} = 4'b0;
        step(2);
        reset = 1'b1;
        step(2);
    endtask

    // mask = {go, h, m, s}
    task automatic press(input logic [3:0] mask);
        {btn_go, btn_h, btn_m, btn_s} = mask;
        step(4);
        {btn_go, btn_h, btn_m, btn_s} = 4'b0;
        step(4);
    endtask

    task automatic press_n(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++)
            press(mask);
    endtask

    // which: 0 = running, 1 = alarm; bounded wait for a level
    task automatic wait_sig(input int which, input logic lvl,
                            input int bound, input string name);
        logic v;
        v = ~lvl;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            v = (which == 0) ? running : alarm;
            if (v === lvl)
                break;
        end
        chk_b(name, v, lvl);
    endtask

    task automatic start(input string name);
        btn_go = 1'b1;
        wait_sig(0, 1'b1, 10, name);
        btn_go = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total, k, rem, ns, nm, nh;
        ev[0] = '{61, 2, 25, 24'h010201};
        ev[1] = '{59, 59, 23, 24'h235959};
        ev[2] = '{60, 60, 24, 24'h000000};
        ev[3] = '{10, 9, 9, 24'h090910};

        reset = 1'b0;
        set_sw = 1'b0;
        {btn_go, btn_h, btn_m, btn_s} = 4'b0;
        step(3);
        chk_d("reset_digits", dig, 24'h0);
        chk_b("reset_running", running, 1'b0);
        chk_b("reset_alarm", alarm, 1'b0);
        reset = 1'b1;
        step(2);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            set_sw = 1'b1;
            press_n(4'b0001, ev[i].ns);
            press_n(4'b0010, ev[i].nm);
            press_n(4'b0100, ev[i].nh);
            chk_d($sformatf("edit_vec%0d", i), dig, ev[i].exp);
        end

        do_reset();
        set_sw = 1'b1;
        press(4'b0011);
        press(4'b0111);
        chk_d("simultaneous_edit", dig, 24'h010202);

        do_reset();
        press(4'b1000);
        step(10);
        chk_b("go_at_zero_running", running, 1'b0);
        chk_d("go_at_zero_digits", dig, 24'h0);

        do_reset();
        set_sw = 1'b1;
        press(4'b0010);
        set_sw = 1'b0;
        start("start_1min");
        step(3);
        chk_d("before_first_tick", dig, 24'h000100);
        step(1);
        chk_d("first_tick", dig, 24'h000059);
        step(236);
        chk_d("expiry_digits", dig, 24'h0);
        chk_b("expiry_alarm", alarm, 1'b1);
        chk_b("expiry_running", running, 1'b0);
        step(11);
        chk_b("alarm_held", alarm, 1'b1);
        step(1);
        chk_b("alarm_timeout", alarm, 1'b0);
        chk_b("idle_after_alarm", running, 1'b0);
        chk_d("digits_after_timeout", dig, RELOAD_60);

        do_reset();
        set_sw = 1'b1;
        press(4'b0100);
        set_sw = 1'b0;
        start("start_1h");
        step(4);
        chk_d("double_borrow", dig, 24'h005959);

        do_reset();
        set_sw = 1'b1;
        press_n(4'b0001, 30);
        set_sw = 1'b0;
        start("start_pause");
        step(2);
        btn_go = 1'b1;
        wait_sig(0, 1'b0, 10, "pause_enter");
        btn_go = 1'b0;
        chk_d("pause_digits", dig, 24'h000029);
        step(40);
        chk_d("pause_frozen", dig, 24'h000029);
        chk_b("pause_running", running, 1'b0);
        start("resume");
        step(3);
        chk_d("resume_hold", dig, 24'h000029);
        step(1);
        chk_d("resume_tick", dig, 24'h000028);

        do_reset();
        set_sw = 1'b1;
        press(4'b0010);
        press_n(4'b0001, 30);
        set_sw = 1'b0;
        start("start_130");
        step(4);
        chk_d("run_130_tick", dig, 24'h000129);
        set_sw = 1'b1;
        step(1);
        chk_b("set_sw_to_idle", running, 1'b0);
        step(8);
        chk_d("set_sw_retained", dig, 24'h000129);
        set_sw = 1'b0;
        start("restart_129");
        step(2);
        #2;
        reset = 1'b0;
        #1;
        chk_d("async_reset_digits", dig, 24'h0);
        chk_b("async_reset_running", running, 1'b0);
        chk_b("async_reset_alarm", alarm, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(2);

        do_reset();
        set_sw = 1'b1;
        press_n(4'b0001, 5);
        set_sw = 1'b0;
        start("start_5s");
        step(20);
        chk_b("alarm_5s", alarm, 1'b1);
        chk_d("alarm_5s_digits", dig, 24'h0);
        btn_s = 1'b1;
        wait_sig(1, 1'b0, 6, "ack_drop");
        btn_s = 1'b0;
        chk_b("ack_running", running, 1'b0);
        chk_d("ack_digits", dig, RELOAD_5);

        for (int it = 0; it < 6; it++) begin
            do_reset();
            ns = int'($urandom_range(0, 70));
            nm = int'($urandom_range(0, 3));
            nh = int'($urandom_range(0, 2));
            set_sw = 1'b1;
            press_n(4'b0001, ns);
            press_n(4'b0010, nm);
            press_n(4'b0100, nh);
            set_sw = 1'b0;
            total = (ns % 60) + (nm % 60) * 60 + (nh % 24) * 3600;
            chk_d($sformatf("rand%0d_preset", it), dig, to_bcd(total));
            if (total > 0) begin
                k = int'($urandom_range(1, (total < 25) ? total : 25));
                start($sformatf("rand%0d_start", it));
                step(4 * k);
                rem = total - k;
                chk_d($sformatf("rand%0d_run", it), dig, to_bcd(rem));
                chk_b($sformatf("rand%0d_alarm", it), alarm, rem == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting HH:MM:SS timer; the counterpart to the up-counting digital clock. Same clock-board domain.
- The user presets the time with s/m/h buttons, then starts it. The timer decrements once per second and raises an alarm at 00:00:00.
- Outputs are six BCD digits that feed the existing 7-segment decoders.

Parameters:
- CLK_DIV, 50_000_000, clk cycles per 1 s tick (must be >= 2).
- ALARM_SECS, 10, number of ticks the alarm output is held after expiry.
- SYNC_STAGES, 2, flip-flop stages in the button synchronisers.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- set_sw  in  1  1 = set mode (buttons edit the digits); 0 = normal.
- btn_s  in  1  raw seconds button; active-high.
- btn_m  in  1  raw minutes button; active-high.
- btn_h  in  1  raw hours button; active-high.
- btn_go  in  1  raw start/pause/acknowledge button; active-high.
- digit_sec0, digit_sec1, digit_min0, digit_min1, digit_hour0, digit_hour1  out  4 each  BCD digits; digit 0 is the units digit.
- running  out  1  high in state RUN.
- alarm  out  1  high in state ALARM.

Behaviour:
- Reset (reset=0, asynchronous):
  - all digits = 0; state = IDLE; running = 0; alarm = 0.
  - prescaler and synchroniser flops = 0.
- Buttons:
  - each raw button passes through a SYNC_STAGES synchroniser, then a rising-edge detector, giving a 1-cycle pulse.
  - pulse latency is SYNC_STAGES+1 cycles from the raw edge.
  - a held button yields exactly one pulse.
- Tick:
  - the prescaler counts 0..CLK_DIV-1 only while in RUN or ALARM; tick fires at CLK_DIV-1.
  - the prescaler clears on every entry to RUN or ALARM, so the first tick comes CLK_DIV cycles after entry.
- States: IDLE, RUN, PAUSE, ALARM.
- IDLE:
  - with set_sw=1: s-pulse increments seconds 00..59, m-pulse increments minutes 00..59, h-pulse increments hours 00..23.
  - each field wraps to 00 independently, with no carry into the next field.
  - go-pulse with set_sw=0 and a nonzero time -> RUN; with time == 00:00:00 the go-pulse is ignored.
  - if two edit pulses arrive in the same cycle, both fields update.
- RUN:
  - each tick decrements with borrow: seconds 00 -> 59 and borrow from minutes; minutes 00 -> 59 and borrow from hours.
  - when a tick produces 00:00:00 -> ALARM in the same cycle the digits show 00:00:00.
  - go-pulse -> PAUSE; a tick coincident with the go-pulse is applied first.
  - set_sw=1 -> IDLE, time retained.
- PAUSE:
  - digits frozen.
  - go-pulse -> RUN.
  - set_sw=1 -> IDLE.
- ALARM:
  - alarm=1; counts ALARM_SECS ticks, then -> IDLE.
  - any button pulse -> IDLE immediately (acknowledge).
  - edit pulses are ignored while in ALARM.
- Digits never hold a non-BCD value or exceed 23:59:59.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - a preset register captures the digits on each IDLE -> RUN transition.
  - on ALARM -> IDLE (timeout or acknowledge), the digits reload from the preset.
  - the preset register clears on reset.
- Undefined: the digits stay at 00:00:00 after the alarm and no preset register exists.

Decomposition:
- Package countdown_pkg:
  - state enum (IDLE, RUN, PAUSE, ALARM).
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - BCD digit typedef (4 bits).
- Sub-module btn_sync_edge (parameter SYNC_STAGES): synchroniser plus rising-edge pulse; instantiated four times.
- The BCD field increment/decrement is a function in the package, not a separate module.

Test Plan (CLK_DIV=4, ALARM_SECS=3):
- Reset mid-RUN at 00:01:30 -> all digits 0, state IDLE, running=0 and alarm=0 immediately, without waiting for a clock edge.
- set_sw=1 with 61 s-pulses, 2 m-pulses and 25 h-pulses -> digits show 01:02:01 (seconds and hours wrap, no carry).
- Preset 00:01:00, go -> after 4 cycles 00:00:59; after 60 ticks 00:00:00 with alarm=1; alarm drops after 3 more ticks; state IDLE.
- Preset 01:00:00 in RUN, one tick -> 00:59:59 (double borrow).
- go at time 00:00:00 in IDLE -> remains IDLE with running=0. In RUN: go -> PAUSE with digits frozen for 40 cycles; go again -> RUN resumes, first decrement 4 cycles later.
- COUNTDOWN_AUTO_RELOAD_EN: preset 00:00:05, run to alarm, press btn_s during alarm -> IDLE with digits 00:00:05. Without the macro -> 00:00:00.
